// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, branch condition codes and NZCV bit positions.
package pipe_pkg;

    localparam int PIPE_DATA_W     = 64;
    localparam int PIPE_REG_ADDR_W = 5;

    // ALU opcodes carried through EX.
    typedef enum logic [3:0] {
        OP_SUB = 4'b0010,
        OP_ADD = 4'b0100,
        OP_CMP = 4'b1010,
        OP_MOV = 4'b1101
    } opcode_e;

    // Branch condition codes that this pipeline resolves; anything else is never taken.
    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_HI = 4'b1000,
        COND_LT = 4'b1011,
        COND_AL = 4'b1110
    } cond_e;

    // Bit positions inside the {N,Z,C,V} flag vector.
    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational condition-code evaluator: decides whether a condition passes
// against a given NZCV flag set. Kept standalone for later predicated execution.
module cond_check
    import pipe_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] nzcv_i,
    output logic       pass_o
);

    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;

    assign flag_n = nzcv_i[NZCV_N];
    assign flag_z = nzcv_i[NZCV_Z];
    assign flag_c = nzcv_i[NZCV_C];
    assign flag_v = nzcv_i[NZCV_V];

    // Decode the condition; unsupported codes fall through to "not taken".
    always_comb begin
        // NOTE: assign a default before the case so every path drives pass_o and no latch is inferred.
        pass_o = 1'b0;
        case (cond_i)
            COND_EQ: pass_o = flag_z;
            COND_NE: pass_o = ~flag_z;
            COND_HI: pass_o = flag_c & ~flag_z;
            COND_LT: pass_o = flag_n ^ flag_v;
            COND_AL: pass_o = 1'b1;
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register. Latches the ALU result and EX control into MEM,
// owns the architectural NZCV flags and resolves conditional branches against
// them, producing a registered one-cycle redirect. Supports stall, flush and
// self-squash of the instruction sitting in the branch shadow.
module ex_mem_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W     = PIPE_DATA_W,
    parameter int REG_ADDR_W = PIPE_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  ex_valid,
    input  logic [DATA_W-1:0]     ex_alu_result,
    input  logic                  ex_set_cond,
    input  logic                  ex_n,
    input  logic                  ex_z,
    input  logic                  ex_c,
    input  logic                  ex_v,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic [DATA_W-1:0]     ex_store_data,
    input  logic                  ex_is_branch,
    input  logic [3:0]            ex_cond,
    input  logic [DATA_W-1:0]     ex_branch_target,
    output logic                  mem_valid,
    output logic [DATA_W-1:0]     mem_alu_result,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  mem_reg_write,
    output logic                  mem_mem_read,
    output logic                  mem_mem_write,
    output logic [DATA_W-1:0]     mem_store_data,
    output logic [3:0]            cpsr_nzcv,
    output logic                  branch_taken,
    output logic [DATA_W-1:0]     branch_target
);

    logic                  valid_q,     valid_d;
    logic [DATA_W-1:0]     result_q,    result_d;
    logic [REG_ADDR_W-1:0] rd_q,        rd_d;
    logic                  reg_write_q, reg_write_d;
    logic                  mem_read_q,  mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [DATA_W-1:0]     store_q,     store_d;
    logic [3:0]            nzcv_q,      nzcv_d;
    logic                  taken_q,     taken_d;
    logic [DATA_W-1:0]     target_q,    target_d;

    logic ev;
    logic cond_pass;

    // The instruction in EX is real unless flushed or sitting in the shadow of a
    // redirect that is leaving this stage right now.
    assign ev = ex_valid & ~flush & ~taken_q;

    // Branches resolve against the flags already committed, never the ones
    // being produced by the same instruction.
    cond_check u_cond_check (
        .cond_i (ex_cond),
        .nzcv_i (nzcv_q),
        .pass_o (cond_pass)
    );

    // Next-state: hold everything on stall, otherwise advance EX into MEM.
    always_comb begin
        valid_d     = valid_q;
        result_d    = result_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        store_d     = store_q;
        nzcv_d      = nzcv_q;
        taken_d     = taken_q;
        target_d    = target_q;

        if (!stall) begin
            valid_d     = ev;
            result_d    = ex_alu_result;
            rd_d        = ex_rd;
            store_d     = ex_store_data;
            reg_write_d = ex_reg_write & ev;
            mem_read_d  = ex_mem_read & ev;
            mem_write_d = ex_mem_write & ev;
            taken_d     = ev & ex_is_branch & cond_pass;

            if (ev && ex_set_cond) begin
                nzcv_d = {ex_n, ex_z, ex_c, ex_v};
            end
            if (ev && ex_is_branch && cond_pass) begin
                target_d = ex_branch_target;
            end
        end
    end

    // State registers; reset discards any in-flight instruction and pending redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            result_q    <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            store_q     <= '0;
            nzcv_q      <= 4'b0000;
            taken_q     <= 1'b0;
            target_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            valid_q     <= valid_d;
            result_q    <= result_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            store_q     <= store_d;
            nzcv_q      <= nzcv_d;
            taken_q     <= taken_d;
            target_q    <= target_d;
        end
    end

    assign mem_valid      = valid_q;
    assign mem_alu_result = result_q;
    assign mem_rd         = rd_q;
    assign mem_reg_write  = reg_write_q;
    assign mem_mem_read   = mem_read_q;
    assign mem_mem_write  = mem_write_q;
    assign mem_store_data = store_q;
    assign cpsr_nzcv      = nzcv_q;
    assign branch_taken   = taken_q;
    assign branch_target  = target_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: each issued EX cycle pushes its
// hand-computed MEM-side result; an independent monitor pops and compares
// one cycle later.
module tb_ex_mem_stage;

    localparam int DW = 64;
    localparam int RW = 5;

    localparam logic [3:0] C_EQ = 4'b0000;
    localparam logic [3:0] C_HI = 4'b1000;
    localparam logic [3:0] C_LT = 4'b1011;
    localparam logic [3:0] C_AL = 4'b1110;

    typedef struct {
        logic          valid;
        logic [DW-1:0] alu;
        logic          set_cond;
        logic [3:0]    nzcv;
        logic [RW-1:0] rd;
        logic          rw;
        logic          mr;
        logic          mw;
        logic [DW-1:0] sd;
        logic          br;
        logic [3:0]    cond;
        logic [DW-1:0] tgt;
        logic          stall;
        logic          flush;
    } in_t;

    typedef struct {
        string         name;
        logic          valid;
        logic [DW-1:0] alu;
        logic [RW-1:0] rd;
        logic          rw;
        logic          mr;
        logic          mw;
        logic [DW-1:0] sd;
        logic [3:0]    nzcv;
        logic          bt;
        logic [DW-1:0] tgt;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          stall;
    logic          flush;
    logic          ex_valid;
    logic [DW-1:0] ex_alu_result;
    logic          ex_set_cond;
    logic          ex_n, ex_z, ex_c, ex_v;
    logic [RW-1:0] ex_rd;
    logic          ex_reg_write;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic [DW-1:0] ex_store_data;
    logic          ex_is_branch;
    logic [3:0]    ex_cond;
    logic [DW-1:0] ex_branch_target;
    logic          mem_valid;
    logic [DW-1:0] mem_alu_result;
    logic [RW-1:0] mem_rd;
    logic          mem_reg_write;
    logic          mem_mem_read;
    logic          mem_mem_write;
    logic [DW-1:0] mem_store_data;
    logic [3:0]    cpsr_nzcv;
    logic          branch_taken;
    logic [DW-1:0] branch_target;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];

    ex_mem_stage #(.DATA_W(DW), .REG_ADDR_W(RW)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .flush            (flush),
        .ex_valid         (ex_valid),
        .ex_alu_result    (ex_alu_result),
        .ex_set_cond      (ex_set_cond),
        .ex_n             (ex_n),
        .ex_z             (ex_z),
        .ex_c             (ex_c),
        .ex_v             (ex_v),
        .ex_rd            (ex_rd),
        .ex_reg_write     (ex_reg_write),
        .ex_mem_read      (ex_mem_read),
        .ex_mem_write     (ex_mem_write),
        .ex_store_data    (ex_store_data),
        .ex_is_branch     (ex_is_branch),
        .ex_cond          (ex_cond),
        .ex_branch_target (ex_branch_target),
        .mem_valid        (mem_valid),
        .mem_alu_result   (mem_alu_result),
        .mem_rd           (mem_rd),
        .mem_reg_write    (mem_reg_write),
        .mem_mem_read     (mem_mem_read),
        .mem_mem_write    (mem_mem_write),
        .mem_store_data   (mem_store_data),
        .cpsr_nzcv        (cpsr_nzcv),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic compare_all(input exp_t e);
        check({e.name, ".mem_valid"},      DW'(mem_valid),      DW'(e.valid));
        check({e.name, ".mem_alu_result"}, mem_alu_result,      e.alu);
        check({e.name, ".mem_rd"},         DW'(mem_rd),         DW'(e.rd));
        check({e.name, ".mem_reg_write"},  DW'(mem_reg_write),  DW'(e.rw));
        check({e.name, ".mem_mem_read"},   DW'(mem_mem_read),   DW'(e.mr));
        check({e.name, ".mem_mem_write"},  DW'(mem_mem_write),  DW'(e.mw));
        check({e.name, ".mem_store_data"}, mem_store_data,      e.sd);
        check({e.name, ".cpsr_nzcv"},      DW'(cpsr_nzcv),      DW'(e.nzcv));
        check({e.name, ".branch_taken"},   DW'(branch_taken),   DW'(e.bt));
        check({e.name, ".branch_target"},  branch_target,       e.tgt);
    endtask

    function automatic in_t mk_in(
        input logic v, input logic [DW-1:0] alu, input logic sc, input logic [3:0] f,
        input logic [RW-1:0] rd, input logic rw, input logic mr, input logic mw,
        input logic [DW-1:0] sd, input logic br, input logic [3:0] cond,
        input logic [DW-1:0] tgt, input logic st, input logic fl);
        in_t s;
        s.valid = v;  s.alu = alu; s.set_cond = sc; s.nzcv = f;
        s.rd = rd;    s.rw = rw;   s.mr = mr;       s.mw = mw;
        s.sd = sd;    s.br = br;   s.cond = cond;   s.tgt = tgt;
        s.stall = st; s.flush = fl;
        return s;
    endfunction

    function automatic exp_t mk_exp(
        input string name, input logic v, input logic [DW-1:0] alu, input logic [RW-1:0] rd,
        input logic rw, input logic mr, input logic mw, input logic [DW-1:0] sd,
        input logic [3:0] f, input logic bt, input logic [DW-1:0] tgt);
        exp_t e;
        e.name = name; e.valid = v; e.alu = alu; e.rd = rd; e.rw = rw; e.mr = mr;
        e.mw = mw; e.sd = sd; e.nzcv = f; e.bt = bt; e.tgt = tgt;
        return e;
    endfunction

    task automatic apply(input in_t s);
        ex_valid         = s.valid;
        ex_alu_result    = s.alu;
        ex_set_cond      = s.set_cond;
        {ex_n, ex_z, ex_c, ex_v} = s.nzcv;
        ex_rd            = s.rd;
        ex_reg_write     = s.rw;
        ex_mem_read      = s.mr;
        ex_mem_write     = s.mw;
        ex_store_data    = s.sd;
        ex_is_branch     = s.br;
        ex_cond          = s.cond;
        ex_branch_target = s.tgt;
        stall            = s.stall;
        flush            = s.flush;
    endtask

    // Drive one EX cycle and record what MEM must show after the next edge.
    task automatic issue(input in_t s, input exp_t e);
        @(posedge clk);
        #2;
        apply(s);
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle with an outstanding expectation, compare all MEM outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                compare_all(e);
            end
        end
    end

    // Hard bound so the run can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog");
    end

    in_t  idle;
    exp_t zero_e;

    initial begin
        idle = mk_in(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
        apply(idle);
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        zero_e = mk_exp("reset_init", 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
        compare_all(zero_e);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // CMP 7,7 then BEQ 0x100, then a shadow ADD that must be squashed.
        issue(mk_in(1, 0, 1, 4'b0110, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
              mk_exp("cmp77", 1, 0, 0, 0, 0, 0, 0, 4'b0110, 0, 0));
        issue(mk_in(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, C_EQ, 64'h100, 0, 0),
              mk_exp("beq", 1, 0, 0, 0, 0, 0, 0, 4'b0110, 1, 64'h100));
        issue(mk_in(1, 64'h55, 1, 4'b1000, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0),
              mk_exp("beq_shadow", 0, 64'h55, 3, 0, 0, 0, 0, 4'b0110, 0, 64'h100));

        // CMP 5,3 then BHI (taken), idle shadow; CMP 5,3 then BLT (not taken).
        issue(mk_in(1, 2, 1, 4'b0010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
              mk_exp("cmp53", 1, 2, 0, 0, 0, 0, 0, 4'b0010, 0, 64'h100));
        issue(mk_in(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, C_HI, 64'h200, 0, 0),
              mk_exp("bhi", 1, 0, 0, 0, 0, 0, 0, 4'b0010, 1, 64'h200));
        issue(idle, mk_exp("bhi_shadow", 0, 0, 0, 0, 0, 0, 0, 4'b0010, 0, 64'h200));
        issue(mk_in(1, 2, 1, 4'b0010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
              mk_exp("cmp53b", 1, 2, 0, 0, 0, 0, 0, 4'b0010, 0, 64'h200));
        issue(mk_in(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, C_LT, 64'h300, 0, 0),
              mk_exp("blt_not_taken", 1, 0, 0, 0, 0, 0, 0, 4'b0010, 0, 64'h200));

        // CMP 7,7 then ADD 3+4 with set_cond=0: flags hold.
        issue(mk_in(1, 0, 1, 4'b0110, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
              mk_exp("cmp77b", 1, 0, 0, 0, 0, 0, 0, 4'b0110, 0, 64'h200));
        issue(mk_in(1, 7, 0, 4'b0000, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0),
              mk_exp("add", 1, 7, 5, 1, 0, 0, 0, 4'b0110, 0, 64'h200));

        // LDR into MEM, then 3 stall cycles (flags offered, flush mid-stall): everything holds.
        issue(mk_in(1, 64'h1000, 0, 4'b0000, 6, 1, 1, 0, 0, 0, 0, 0, 0, 0),
              mk_exp("ldr", 1, 64'h1000, 6, 1, 1, 0, 0, 4'b0110, 0, 64'h200));
        for (int i = 0; i < 3; i++) begin
            issue(mk_in(1, 64'h2000, 1, 4'b1001, 0, 0, 0, 1, 64'hdead, 0, 0, 0, 1, (i == 1)),
                  mk_exp("ldr_stall", 1, 64'h1000, 6, 1, 1, 0, 0, 4'b0110, 0, 64'h200));
        end
        issue(mk_in(1, 64'h2000, 0, 4'b0000, 0, 0, 0, 1, 64'hdead, 0, 0, 0, 0, 0),
              mk_exp("str", 1, 64'h2000, 0, 0, 0, 1, 64'hdead, 4'b0110, 0, 64'h200));

        // Flushed CMP: bubble, flags untouched.
        issue(mk_in(1, 0, 1, 4'b0001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1),
              mk_exp("flush_cmp", 0, 0, 0, 0, 0, 0, 0, 4'b0110, 0, 64'h200));

        // BAL, stall holds the redirect, then the shadow ADD is squashed.
        issue(mk_in(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, C_AL, 64'h400, 0, 0),
              mk_exp("bal", 1, 0, 0, 0, 0, 0, 0, 4'b0110, 1, 64'h400));
        issue(mk_in(1, 9, 1, 4'b1000, 7, 1, 0, 0, 0, 0, 0, 0, 1, 0),
              mk_exp("bal_stall", 1, 0, 0, 0, 0, 0, 0, 4'b0110, 1, 64'h400));
        issue(mk_in(1, 9, 1, 4'b1000, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0),
              mk_exp("bal_shadow", 0, 9, 7, 0, 0, 0, 0, 4'b0110, 0, 64'h400));
        issue(idle, mk_exp("idle", 0, 0, 0, 0, 0, 0, 0, 4'b0110, 0, 64'h400));

        // BEQ taken, then async reset mid-cycle while mem_valid=1 and branch_taken=1.
        issue(mk_in(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, C_EQ, 64'h500, 0, 0),
              mk_exp("beq2", 1, 0, 0, 0, 0, 0, 0, 4'b0110, 1, 64'h500));
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        zero_e.name = "reset_mid";
        compare_all(zero_e);
        apply(idle);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // After reset: CMP 5,3; illegal BLT with set_cond (old flags, not taken,
        // flags still written); BLT now taken on N!=V; idle shadow.
        issue(mk_in(1, 2, 1, 4'b0010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
              mk_exp("cmp53_post_rst", 1, 2, 0, 0, 0, 0, 0, 4'b0010, 0, 0));
        issue(mk_in(1, 0, 1, 4'b1000, 0, 0, 0, 0, 0, 1, C_LT, 64'h600, 0, 0),
              mk_exp("blt_setcond", 1, 0, 0, 0, 0, 0, 0, 4'b1000, 0, 0));
        issue(mk_in(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, C_LT, 64'h700, 0, 0),
              mk_exp("blt_taken", 1, 0, 0, 0, 0, 0, 0, 4'b1000, 1, 64'h700));
        issue(idle, mk_exp("blt_shadow", 0, 0, 0, 0, 0, 0, 0, 4'b1000, 0, 64'h700));

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #2;
        end
        check("scoreboard_drain", DW'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
